// File: rtl/mem_port_master.sv
// Initiator for the word-addressed RAM port: one direct or indirect load/store at a time.
// Optional build macro MEM_BOUNDS_CHECK_EN rejects direct requests above the indirect pointer.
module mem_port_master #(
  parameter int unsigned       ADDR_W    = 11,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] INDA_ADDR = 11'h204,
  parameter logic [ADDR_W-1:0] INDV_ADDR = 11'h203,
  parameter logic [ADDR_W-1:0] PTR_MASK  = 11'h1FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_indirect,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] in_data,
  output logic              write_enable,
  input  logic [DATA_W-1:0] out_data
);

  typedef enum logic [2:0] {StIdle, StPtrWr, StAccess, StRdWait, StResp} state_e;

  state_e state_q, state_d;

  logic              req_write_q;
  logic              req_ind_q;
  logic              req_err_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              we_q, we_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic accept;
  logic bounds_err;

`ifdef MEM_BOUNDS_CHECK_EN
  assign bounds_err = !req_indirect && (req_addr > INDA_ADDR);
`else
  assign bounds_err = 1'b0;
`endif

  // Ready stays low through the response cycle so the next accept follows it.
  assign req_ready = (state_q == StIdle) && !resp_valid_q && !reset;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      req_write_q  <= 1'b0;
      req_ind_q    <= 1'b0;
      req_err_q    <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      addr_q       <= '0;
      in_data_q    <= '0;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      in_data_q    <= in_data_d;
      we_q         <= we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (accept) begin
        req_write_q <= req_write;
        req_ind_q   <= req_indirect;
        req_err_q   <= bounds_err;
        req_addr_q  <= req_addr;
        req_wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bounds_err)        state_d = StResp;
          else if (req_indirect) state_d = StPtrWr;
          else                   state_d = StAccess;
        end
      end
      StPtrWr:  state_d = StAccess;
      StAccess: state_d = req_write_q ? StResp : StRdWait;
      StRdWait: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Port registers are loaded from the state being executed, so they lag the state by one edge.
  always_comb begin
    addr_d       = addr_q;
    in_data_d    = in_data_q;
    we_d         = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = 1'b0;
    unique case (state_q)
      StPtrWr: begin
        addr_d    = INDA_ADDR;
        in_data_d = DATA_W'(req_addr_q & PTR_MASK);
        we_d      = 1'b1;
      end
      StAccess: begin
        addr_d = req_ind_q ? INDV_ADDR : req_addr_q;
        if (req_write_q) begin
          in_data_d = req_wdata_q;
          we_d      = 1'b1;
        end
      end
      StResp: begin
        resp_valid_d = 1'b1;
        resp_err_d   = req_err_q;
        resp_rdata_d = (req_write_q || req_err_q) ? '0 : out_data;
      end
      default: ;
    endcase
  end

  assign addr         = addr_q;
  assign in_data      = in_data_q;
  assign write_enable = we_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: RAM model, flat-array reference memory and response/write scoreboards.
module tb_mem_port_master;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_indirect;
  logic [10:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic [10:0] addr;
  logic [15:0] in_data;
  logic        write_enable;
  logic [15:0] out_data;

  mem_port_master dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_indirect (req_indirect),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .addr         (addr),
    .in_data      (in_data),
    .write_enable (write_enable),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    return (16'(i) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // RAM: write on falling edge, registered read on rising edge, indirect pointer/value registers.
  logic [15:0] ram [2048];
  logic [8:0]  ram_ptr;
  logic        fill = 1'b1;

  always @(negedge clk) begin
    if (fill) begin
      for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
      ram_ptr <= '0;
    end else if (write_enable) begin
      if (addr == 11'h204)      ram_ptr <= in_data[8:0];
      else if (addr == 11'h203) ram[{2'b00, ram_ptr}] <= in_data;
      else                      ram[addr] <= in_data;
    end
  end

  always @(posedge clk) out_data <= (addr == 11'h203) ? ram[{2'b00, ram_ptr}] : ram[addr];

  // Reference: plain word array, addressed by the effective target of each request.
  logic [15:0] model_mem [2048];

  typedef struct { logic [15:0] rdata; logic err; int due; } exp_t;
  typedef struct { logic [10:0] a; logic [15:0] d; } wr_t;
  exp_t rq[$];
  wr_t  wq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_push   = 0;
  int n_resp   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor
  initial forever begin
    @(posedge clk); #1;
    if (resp_valid) begin
      n_resp++;
      chk("ready_low_during_resp", {31'b0, req_ready}, 32'd0);
      if (rq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = rq.pop_front();
        chk("resp_rdata", {16'b0, resp_rdata}, {16'b0, e.rdata});
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_latency", cyc, e.due);
      end
    end
  end

  // Write monitor
  initial forever begin
    @(posedge clk); #1;
    if (write_enable) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {21'b0, addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("write_addr", {21'b0, addr}, {21'b0, w.a});
        chk("write_data", {16'b0, in_data}, {16'b0, w.d});
      end
    end
  end

  // Issue one request; called and returns at 1 time unit after a rising edge.
  task automatic issue(input logic w, input logic ind, input logic [10:0] a, input logic [15:0] d,
                       input bit expect_resp, output int acc);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_indirect = ind; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      $display("FAIL accept_timeout: req_ready stuck low, got 0 expected 1");
      $fatal(1);
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    if (expect_resp) begin
      exp_t e;
      logic [10:0] eff;
      eff = ind ? (a & 11'h1FF) : a;
      e.err = BoundsEn && !ind && (a > 11'h204);
      e.rdata = '0;
      e.due = acc + (e.err ? 1 : (2 + (w ? 0 : 1) + (ind ? 1 : 0)));
      if (!e.err) begin
        if (ind) wq.push_back('{a: 11'h204, d: {7'b0, eff[8:0]}});
        if (w) begin
          model_mem[eff] = d;
          wq.push_back('{a: (ind ? 11'h203 : a), d: d});
        end else begin
          e.rdata = model_mem[eff];
        end
      end
      rq.push_back(e);
      n_push++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a1, a2, acc;
    for (int i = 0; i < 2048; i++) model_mem[i] = init_val(i);
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_indirect = 1'b0;
    req_addr = '0; req_wdata = '0;
    @(negedge clk); #1 fill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_we", {31'b0, write_enable}, 32'd0);
    chk("rst_addr", {21'b0, addr}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ready", {31'b0, req_ready}, 32'd1);

    // Direct store then load
    issue(1'b1, 1'b0, 11'h010, 16'hBEEF, 1'b1, acc);
    issue(1'b0, 1'b0, 11'h010, 16'h0000, 1'b1, acc);
    // Indirect store, then direct read-back
    issue(1'b1, 1'b1, 11'h155, 16'h1234, 1'b1, acc);
    issue(1'b0, 1'b0, 11'h155, 16'h0000, 1'b1, acc);
    // Pointer masking: 0x3A0 -> 0x1A0
    issue(1'b1, 1'b0, 11'h1A0, 16'h5A5A, 1'b1, acc);
    issue(1'b0, 1'b1, 11'h3A0, 16'h0000, 1'b1, acc);

    // Back-pressure: second request held while a load is outstanding
    issue(1'b0, 1'b0, 11'h011, 16'h0000, 1'b1, a1);
    issue(1'b0, 1'b0, 11'h012, 16'h0000, 1'b1, a2);
    chk("backpressure_gap", a2 - a1, 32'd5);

    // Reset during RD_WAIT
    repeat (5) begin @(posedge clk); #1; end
    issue(1'b0, 1'b0, 11'h040, 16'h0000, 1'b0, acc);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_addr", {21'b0, addr}, 32'd0);
    chk("midrst_in_data", {16'b0, in_data}, 32'd0);
    chk("midrst_we", {31'b0, write_enable}, 32'd0);
    chk("midrst_resp", {31'b0, resp_valid}, 32'd0);
    chk("midrst_rdata", {16'b0, resp_rdata}, 32'd0);
    chk("midrst_err", {31'b0, resp_err}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    repeat (6) begin @(posedge clk); #1; end

    // Out-of-range direct store
    issue(1'b1, 1'b0, 11'h300, 16'hC0DE, 1'b1, acc);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      logic w, ind;
      logic [10:0] a;
      w   = 1'($urandom_range(0, 1));
      ind = 1'($urandom_range(0, 1));
      a   = ind ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 511));
      issue(w, ind, a, 16'($urandom), 1'b1, acc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    for (int t = 0; t < 100 && rq.size() != 0; t++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    chk("resp_count", n_resp, n_push);
    chk("resp_queue_drained", rq.size(), 32'd0);
    chk("write_queue_drained", wq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
